// File: rtl/obc1_pkg.sv
// rtl/obc1_pkg.sv - shared constants, FSM state and request types for the OBC1 block
package obc1_pkg;

    localparam int          RAM_AW       = 11;
    localparam logic [10:0] HI_TABLE_OFS = 11'h200;
    localparam logic [10:0] BASE_ALT     = 11'h400;

    localparam logic [10:0] OFS_ATTR0 = 11'h7F0;
    localparam logic [10:0] OFS_ATTR1 = 11'h7F1;
    localparam logic [10:0] OFS_ATTR2 = 11'h7F2;
    localparam logic [10:0] OFS_ATTR3 = 11'h7F3;
    localparam logic [10:0] OFS_HI    = 11'h7F4;
    localparam logic [10:0] OFS_BASE  = 11'h7F5;
    localparam logic [10:0] OFS_INDEX = 11'h7F6;

    typedef enum logic [1:0] {
        IDLE,
        RMW_RD,
        RMW_MERGE,
        RMW_WR
    } obc1_state_t;

    // One bus access: write flag, window offset and write data
    typedef struct packed {
        logic        wr;
        logic [10:0] addr;
        logic [7:0]  data;
    } obc1_req_t;

endpackage

// File: rtl/obc1_if.sv
// rtl/obc1_if.sv - SNES-side strobe and data bundle for the OBC1 block
interface obc1_if;
    logic        enable;
    logic [10:0] addr_in;
    logic [7:0]  data_in;
    logic        reg_rd_start;
    logic        reg_we_end;
    logic [7:0]  data_out;
    logic        busy;

    modport master (
        output enable, addr_in, data_in, reg_rd_start, reg_we_end,
        input  data_out, busy
    );

    modport slave (
        input  enable, addr_in, data_in, reg_rd_start, reg_we_end,
        output data_out, busy
    );
endinterface

// File: rtl/obc1_ram.sv
// rtl/obc1_ram.sv - single-port read-first synchronous RAM, one-cycle registered read
module obc1_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [7:0]    wd,
    output logic [7:0]    q
);
    logic [7:0] mem [0:(1<<AW)-1];

    // Read-first port: q always returns the contents before this cycle's write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wd;
        end
        q <= mem[addr];
    end
endmodule

// File: rtl/obc1.sv
// rtl/obc1.sv - OBC1 object-attribute coprocessor with indexed window and 2-bit RMW path
module obc1 (
    input  logic  CLK,
    input  logic  RST,
    obc1_if.slave bus
);
    import obc1_pkg::*;

    obc1_state_t state;
    logic        base_sel;
    logic [6:0]  index;
    logic        pend_valid;
    obc1_req_t   pend;
    logic        rd_q;
    logic [10:0] rmw_addr;
    logic [2:0]  rmw_sh;
    logic [1:0]  rmw_bits;
    logic [7:0]  rmw_new;

    obc1_req_t   live;
    obc1_req_t   op;
    logic        live_valid;
    logic        op_valid;
    logic        is_attr;
    logic        is_hi;
    logic [10:0] base;
    logic [10:0] lo_addr;
    logic [10:0] hi_addr;

    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wd;
    logic [7:0]  ram_q;

    // Select the request to serve: a parked request takes priority over a new strobe
    always_comb begin
        live.wr    = bus.reg_we_end;
        live.addr  = bus.addr_in;
        live.data  = bus.data_in;
        live_valid = bus.enable & (bus.reg_we_end | bus.reg_rd_start);
        op         = pend_valid ? pend : live;
        op_valid   = (state == IDLE) & (pend_valid | live_valid);
        is_attr    = (op.addr[10:2] == OFS_ATTR0[10:2]);
        is_hi      = (op.addr == OFS_HI);
        base       = base_sel ? 11'h000 : BASE_ALT;
        lo_addr    = base + {2'b00, index, 2'b00} + {9'b0, op.addr[1:0]};
        hi_addr    = base + HI_TABLE_OFS + {6'b0, index[6:2]};
    end

    // RAM port arbitration: the FSM owns the port outside IDLE, reset blocks any write
    always_comb begin
        ram_addr = rmw_addr;
        ram_we   = 1'b0;
        ram_wd   = rmw_new;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    ram_wd   = op.data;
                    ram_we   = op.wr & ~is_hi;
                    if (is_attr) begin
                        ram_addr = lo_addr;
                    end else if (is_hi) begin
                        ram_addr = hi_addr;
                    end else begin
                        ram_addr = op.addr;
                    end
                end
            end
            RMW_WR:  ram_we = 1'b1;
            default: ram_we = 1'b0;
        endcase
        if (RST) begin
            ram_we = 1'b0;
        end
    end

    obc1_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk  (CLK),
        .addr (ram_addr),
        .we   (ram_we),
        .wd   (ram_wd),
        .q    (ram_q)
    );

    // Control FSM, shadow registers, pending slot and read-data register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.data_out <= 8'h00;
            rd_q       <= 1'b0;
            pend_valid <= 1'b0;
            base_sel   <= 1'b0;
            index      <= 7'd0;
        end else begin
            rd_q <= op_valid & ~op.wr;
            if (rd_q) begin
                bus.data_out <= ram_q;
            end

            // Park one strobe while the RMW runs; refill the slot as it drains
            if (state != IDLE) begin
                if (live_valid && !pend_valid) begin
                    pend_valid <= 1'b1;
                    pend       <= live;
                end
            end else if (pend_valid) begin
                pend_valid <= live_valid;
                if (live_valid) begin
                    pend <= live;
                end
            end

            case (state)
                IDLE: begin
                    if (op_valid && op.wr) begin
                        if (is_hi) begin
                            rmw_addr <= hi_addr;
                            rmw_sh   <= {index[1:0], 1'b0};
                            rmw_bits <= op.data[1:0];
                            state    <= RMW_RD;
                            bus.busy <= 1'b1;
                        end else if (op.addr == OFS_BASE) begin
                            base_sel <= op.data[0];
                        end else if (op.addr == OFS_INDEX) begin
                            index <= op.data[6:0];
                        end
                    end
                end
                RMW_RD: begin
                    state <= RMW_MERGE;
                end
                RMW_MERGE: begin
                    rmw_new <= (ram_q & ~(8'h03 << rmw_sh)) | ({6'b0, rmw_bits} << rmw_sh);
                    state   <= RMW_WR;
                end
                RMW_WR: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_obc1.sv
// tb/tb_obc1.sv - self-checking bench for obc1 against a behavioural memory model
module tb_obc1;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    obc1_if bus ();
    obc1 dut (.CLK(CLK), .RST(RST), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [0:2047];
    logic       m_base_sel;
    logic [6:0] m_index;

    function automatic int m_base();
        return m_base_sel ? 0 : 'h400;
    endfunction

    function automatic logic [10:0] m_lo(input logic [1:0] k);
        return 11'(m_base() + int'(m_index) * 4 + int'(k));
    endfunction

    function automatic logic [10:0] m_hi();
        return 11'(m_base() + 'h200 + int'(m_index) / 4);
    endfunction

    function automatic logic [7:0] m_read(input logic [10:0] a);
        if (a >= 11'h7F0 && a <= 11'h7F3) return mem[m_lo(a[1:0])];
        if (a == 11'h7F4) return mem[m_hi()];
        return mem[a];
    endfunction

    task automatic m_write(input logic [10:0] a, input logic [7:0] d);
        int sh;
        logic [10:0] h;
        if (a >= 11'h7F0 && a <= 11'h7F3) begin
            mem[m_lo(a[1:0])] = d;
        end else if (a == 11'h7F4) begin
            h  = m_hi();
            sh = 2 * (int'(m_index) % 4);
            mem[h] = (mem[h] & ~8'(3 << sh)) | 8'(int'(d[1:0]) << sh);
        end else begin
            mem[a] = d;
            if (a == 11'h7F5) m_base_sel = d[0];
            if (a == 11'h7F6) m_index = d[6:0];
        end
    endtask

    task automatic strobe(input bit wr, input logic [10:0] a, input logic [7:0] d, input bit en);
        @(negedge CLK);
        bus.enable       = en;
        bus.addr_in      = a;
        bus.data_in      = d;
        bus.reg_we_end   = wr;
        bus.reg_rd_start = !wr;
        @(negedge CLK);
        bus.reg_we_end   = 1'b0;
        bus.reg_rd_start = 1'b0;
        bus.enable       = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic do_write(input logic [10:0] a, input logic [7:0] d);
        strobe(1'b1, a, d, 1'b1);
        m_write(a, d);
        if (a == 11'h7F4) wait_idle();
    endtask

    task automatic do_read(input logic [10:0] a, output logic [7:0] d);
        strobe(1'b0, a, 8'h00, 1'b1);
        @(negedge CLK);
        d = bus.data_out;
    endtask

    task automatic check_read(input string name, input logic [10:0] a, input logic [7:0] exp);
        logic [7:0] got;
        do_read(a, got);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: addr %h read %h, required %h", name, a, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        m_base_sel = 1'b0;
        m_index    = 7'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (bus.data_out !== 8'h00 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: data_out=%h busy=%b, required 00/0", bus.data_out, bus.busy);
        end
        do_write(11'h7F5, 8'h01);
        check_read("read_7f5", 11'h7F5, 8'h01);
    endtask

    task automatic test_fill();
        for (int a = 0; a < 2048; a++) begin
            if (a < 'h7F0 || a > 'h7F4) do_write(11'(a), 8'($urandom));
        end
    endtask

    task automatic test_window();
        do_write(11'h7F5, 8'h00);
        do_write(11'h7F6, 8'h05);
        do_write(11'h7F2, 8'hAB);
        check_read("lo_direct", 11'h416, 8'hAB);
        check_read("lo_window", 11'h7F2, 8'hAB);
    endtask

    task automatic test_rmw();
        int cnt = 0;
        do_write(11'h7F5, 8'h00);
        do_write(11'h7F6, 8'h07);
        do_write(11'h601, 8'hFF);
        strobe(1'b1, 11'h7F4, 8'h02, 1'b1);
        m_write(11'h7F4, 8'h02);
        for (int i = 0; i < 10; i++) begin
            if (bus.busy === 1'b1) cnt++;
            @(negedge CLK);
        end
        vectors++;
        if (cnt != 3) begin
            miscompares++;
            $display("FAIL busy_len: busy for %0d cycles, required 3", cnt);
        end
        check_read("rmw_result", 11'h601, 8'hBF);
    endtask

    task automatic test_base0();
        logic [7:0] old;
        do_write(11'h7F5, 8'h01);
        do_write(11'h7F6, 8'h7F);
        do_write(11'h7F3, 8'h5A);
        check_read("base0_lo", 11'h1FF, 8'h5A);
        old = mem[11'h21F];
        do_write(11'h7F4, 8'h03);
        check_read("base0_hi", 11'h21F, (old & 8'h3F) | 8'hC0);
        check_read("base0_hi_win", 11'h7F4, (old & 8'h3F) | 8'hC0);
    endtask

    task automatic test_defer();
        logic [7:0] v0;
        logic [7:0] h_exp;
        do_write(11'h123, 8'h11);
        do_write(11'h124, 8'h22);
        do_write(11'h125, 8'h33);
        do_read(11'h125, v0);
        @(negedge CLK);
        bus.addr_in = 11'h7F4; bus.data_in = 8'h01; bus.reg_we_end = 1'b1;
        m_write(11'h7F4, 8'h01);
        h_exp = mem[m_hi()];
        @(negedge CLK);
        bus.reg_we_end = 1'b0; bus.reg_rd_start = 1'b1; bus.addr_in = 11'h123;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL defer_busy: busy=%b, required 1", bus.busy);
        end
        @(negedge CLK);
        bus.addr_in = 11'h124;
        @(negedge CLK);
        bus.reg_rd_start = 1'b0;
        @(negedge CLK);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL defer_idle: busy=%b, required 0", bus.busy);
        end
        @(negedge CLK);
        vectors++;
        if (bus.data_out !== v0) begin
            miscompares++;
            $display("FAIL defer_early: data_out=%h, required %h", bus.data_out, v0);
        end
        @(negedge CLK);
        vectors++;
        if (bus.data_out !== 8'h11) begin
            miscompares++;
            $display("FAIL defer_data: data_out=%h, required 11", bus.data_out);
        end
        repeat (2) @(negedge CLK);
        vectors++;
        if (bus.data_out !== 8'h11) begin
            miscompares++;
            $display("FAIL defer_drop: data_out=%h, required 11", bus.data_out);
        end
        check_read("defer_rmw", 11'h7F4, h_exp);
    endtask

    task automatic test_reset_mid();
        logic [10:0] h;
        logic [7:0]  old;
        int          sh;
        h   = m_hi();
        old = mem[h];
        sh  = 2 * (int'(m_index) % 4);
        @(negedge CLK);
        bus.addr_in = 11'h7F4; bus.data_in = 8'(((int'(old) >> sh) & 3) ^ 3); bus.reg_we_end = 1'b1;
        @(negedge CLK);
        bus.reg_we_end = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        m_base_sel = 1'b0;
        m_index    = 7'd0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b data_out=%h, required 0/00", bus.busy, bus.data_out);
        end
        repeat (4) @(negedge CLK);
        check_read("reset_mid_target", h, old);
    endtask

    task automatic test_disabled();
        logic [7:0] va;
        va = mem[11'h050];
        check_read("dis_pre", 11'h050, va);
        strobe(1'b1, 11'h051, ~mem[11'h051], 1'b0);
        strobe(1'b1, 11'h7F5, 8'h01, 1'b0);
        strobe(1'b0, 11'h052, 8'h00, 1'b0);
        repeat (3) @(negedge CLK);
        vectors++;
        if (bus.data_out !== va) begin
            miscompares++;
            $display("FAIL dis_hold: data_out=%h, required %h", bus.data_out, va);
        end
        check_read("dis_ram", 11'h051, mem[11'h051]);
        check_read("dis_base", 11'h7F0, m_read(11'h7F0));
    endtask

    task automatic test_random();
        logic [10:0] a;
        logic [7:0]  d;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7) a = 11'(11'h7F0 + $urandom_range(0, 6));
            else a = 11'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, d);
            else check_read("random", a, m_read(a));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        bus.enable = 1'b1; bus.addr_in = '0; bus.data_in = '0;
        bus.reg_rd_start = 1'b0; bus.reg_we_end = 1'b0;
        m_base_sel = 1'b0; m_index = 7'd0;
        test_reset();
        test_fill();
        test_window();
        test_rmw();
        test_base0();
        test_defer();
        test_reset_mid();
        test_disabled();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/obc1.md
Name: obc1

Overview:
- OBC1 object-attribute coprocessor emulation. Sits directly downstream of the address decoder and consumes its obc1_enable output.
- Owns a 2 KiB internal RAM mapped to SNES $7800-$7FFF in banks $00-$3F/$80-$BF.
- Implements the OBC1 indexed register window at $7FF0-$7FF6. Writes to $7FF4 need a read-modify-write sequence, handled by an internal FSM.

Parameters:
- RAM_AW, 11, RAM address width (2 KiB).
- HI_TABLE_OFS, 11'h200, offset of the 2-bit high-attribute table from the active base.
- BASE_ALT, 11'h400, base used when the base-select bit is 0. Base is 11'h000 when the bit is 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- enable  in  1  obc1_enable from the address decoder; qualifies the strobes.
- addr_in  in  11  SNES_ADDR[10:0].
- data_in  in  8  SNES write data, stable while reg_we_end is high.
- reg_rd_start  in  1  single-cycle pulse at the start of a SNES read.
- reg_we_end  in  1  single-cycle pulse at the end of a SNES write.
- data_out  out  8  read data to the SNES data mux.
- busy  out  1  high while the RMW FSM is not IDLE.

Behaviour:
- Clocking: one clock (CLK). Reset is synchronous and active-high (RST).
- Reset values:
  - data_out = 0, busy = 0, FSM = IDLE, pending slot empty.
  - Shadow registers base_sel = 0 and index = 0, so the active base is BASE_ALT.
  - RAM contents are not reset.
- Strobes are acted on only when enable = 1. Strobes with enable = 0 are ignored and data_out holds its value.
- Shadow registers:
  - A write to 7F5 updates RAM and base_sel := data_in[0].
  - A write to 7F6 updates RAM and index := data_in[6:0].
- Address arithmetic (all 11-bit, no overflow possible):
  - base = base_sel ? 0 : BASE_ALT
  - lo_addr = base + {index,2'b00} + addr_in[1:0]
  - hi_addr = base + HI_TABLE_OFS + index[6:2]
- Read, offset 7F0-7F3: returns RAM[lo_addr].
- Read, offset 7F4: returns RAM[hi_addr].
- Read, any other offset (including 7F5/7F6): returns RAM[addr_in].
- Read latency: strobe in cycle N, RAM address issued in N, data_out valid from N+2 and held until the next read.
- Write, offsets 7F0-7F3: RAM[lo_addr] := data_in, written in N+1.
- Write, other non-7F4 offsets: RAM[addr_in] := data_in, written in N+1.
- Write, offset 7F4: RMW FSM.
  - IDLE -> RMW_RD (N+1): read issued to hi_addr.
  - RMW_RD -> RMW_MERGE (N+2): sh = {index[1:0],1'b0}; new = (old & ~(2'b11<<sh)) | (data_in[1:0]<<sh).
  - RMW_MERGE -> RMW_WR (N+3): RAM[hi_addr] := new.
  - RMW_WR -> IDLE.
  - busy is high in N+1..N+3.
  - hi_addr, sh and data_in are latched at N, so later shadow changes do not affect an in-flight RMW.
- Simultaneous reg_rd_start and reg_we_end: the write is processed and the read is dropped.
- Strobe while busy:
  - It is captured into a one-deep pending slot (type, addr, data) and executed on the first IDLE cycle.
  - A second strobe while the slot is full is dropped.
- Reset mid-RMW: FSM returns to IDLE and busy = 0. No RAM write occurs in the reset cycle or afterwards for that operation. The pending slot is cleared.

Decomposition:
- Shared package obc1_pkg holds:
  - Offset constants OFS_ATTR0..OFS_ATTR3 = 11'h7F0..11'h7F3, OFS_HI = 11'h7F4, OFS_BASE = 11'h7F5, OFS_INDEX = 11'h7F6.
  - HI_TABLE_OFS and BASE_ALT.
  - FSM state typedef {IDLE, RMW_RD, RMW_MERGE, RMW_WR}.
- One sub-module: obc1_ram, a 2Kx8 single-port synchronous RAM, read-first, 1-cycle registered read. It is the BRAM inference wrapper.

Test Plan:
- Reset -> data_out = 8'h00, busy = 0. Write 7F5 = 8'h01, then read 7F5 -> data_out = 8'h01 at N+2.
- Write 7F5 = 8'h00, 7F6 = 8'h05, 7F2 = 8'hAB -> RAM[11'h416] = 8'hAB. Read addr 11'h416 returns 8'hAB. Read 7F2 also returns 8'hAB.
- Base 11'h400, index 8'h07, RAM[11'h601] preloaded to 8'hFF. Write 7F4 = 8'h02 -> RAM[11'h601] = 8'hBF, busy high for exactly 3 cycles.
- Write 7F5 = 8'h01, 7F6 = 8'h7F, 7F3 = 8'h5A -> RAM[11'h1FF] = 8'h5A. Write 7F4 = 8'h03 modifies bits 7:6 of RAM[11'h21F] only.
- Read strobe issued one cycle after a 7F4 write -> read deferred; data_out valid 2 cycles after FSM returns to IDLE. A third strobe in the same window is dropped.
- RST asserted in RMW_MERGE -> busy = 0 next cycle, target byte unchanged. Strobes with enable = 0 leave RAM and data_out unchanged.
